// File: rtl/waveform_averager_pkg.sv
// Shared types and helpers for the waveform averager.
//   state_t : controller state encoding
//   clog2   : constant ceil(log2(value)), 0 for value <= 1
package waveform_averager_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StEventDone,
        StReadout
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/avg_acc_ram.sv
// Accumulator storage: DEPTH x WIDTH, one asynchronous read port and one
// synchronous write port. A read and a write to the same address in one cycle
// returns the old contents, so a read-modify-write completes every cycle.
// Ports:
//   clk     : clock
//   wrEn    : write enable
//   wrAddr  : write address
//   wrData  : write data
//   rdAddr  : read address
//   rdData  : read data (old contents on a same-cycle write)
module avg_acc_ram
    import waveform_averager_pkg::*;
#(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned WIDTH = 14,
    localparam int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [WIDTH-1:0]  wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [WIDTH-1:0]  rdData
);

    // No reset: the first event of every average overwrites each entry.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/waveform_averager.sv
// Multi-event waveform averager. Each capture_strobe records RECORD_LEN samples
// into an accumulator; after NUM_EVENTS records the sums are streamed out over
// a valid/ready interface.
// Optional feature: define WAVEFORM_AVG_DIVIDE_EN to output sum >> log2(NUM_EVENTS)
// instead of the raw sum.
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   sample_in      : ADC sample, valid every cycle
//   capture_strobe : starts one event record when idle
//   out_ready      : downstream accepts a word
//   out_valid      : out_data valid
//   out_data       : averaged or summed sample
//   out_last       : marks the final word of a readout
//   busy           : controller not idle
//   strobe_dropped : pulse when capture_strobe is ignored
module waveform_averager
    import waveform_averager_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 8,
    parameter int unsigned RECORD_LEN = 128,
    parameter int unsigned NUM_EVENTS = 64,
    localparam int unsigned ACC_W     = SAMPLE_W + clog2(NUM_EVENTS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                capture_strobe,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [ACC_W-1:0]    out_data,
    output logic                out_last,
    output logic                busy,
    output logic                strobe_dropped
);

    localparam int unsigned EVT_LOG2 = clog2(NUM_EVENTS);
    localparam int unsigned IDX_W    = clog2(RECORD_LEN);
    localparam int unsigned EVT_W    = EVT_LOG2 + 1;  // must hold NUM_EVENTS itself
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RECORD_LEN - 1);
    localparam logic [EVT_W-1:0] EVT_FULL  = EVT_W'(NUM_EVENTS);

    state_t             stateQ, stateD;
    logic [IDX_W-1:0]   idxQ, idxD;      // sample index in CAPTURE, word index in READOUT
    logic [EVT_W-1:0]   evtQ, evtD;
    logic [EVT_W-1:0]   evtNext;
    logic               idxLast;
    logic               wrEn;
    logic [ACC_W-1:0]   wrData;
    logic [ACC_W-1:0]   rdData;

    assign idxLast = (idxQ == LAST_IDX);
    assign evtNext = evtQ + EVT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:      if (capture_strobe) stateD = StCapture;
            StCapture:   if (idxLast) stateD = StEventDone;
            StEventDone: stateD = (evtNext == EVT_FULL) ? StReadout : StIdle;
            StReadout:   if (out_ready && idxLast) stateD = StIdle;
            default:     stateD = StIdle;
        endcase
    end

    // Index and event counters
    always_comb begin
        idxD = idxQ;
        evtD = evtQ;
        unique case (stateQ)
            StCapture: idxD = idxLast ? '0 : idxQ + IDX_W'(1);
            StEventDone: evtD = evtNext;
            StReadout: begin
                if (out_ready) begin
                    if (idxLast) begin
                        idxD = '0;
                        evtD = '0;
                    end else begin
                        idxD = idxQ + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idxQ <= '0;
            evtQ <= '0;
        end else begin
            idxQ <= idxD;
            evtQ <= evtD;
        end
    end

    // Outputs and accumulator write path
    always_comb begin
        busy           = (stateQ != StIdle);
        out_valid      = (stateQ == StReadout);
        out_last       = out_valid && idxLast;
        strobe_dropped = capture_strobe && busy;
        wrEn           = (stateQ == StCapture);
        // Event 0 overwrites, so stale RAM contents never leak into a sum.
        wrData         = (evtQ == '0) ? ACC_W'(sample_in) : rdData + ACC_W'(sample_in);
`ifdef WAVEFORM_AVG_DIVIDE_EN
        out_data       = rdData >> EVT_LOG2;
`else
        out_data       = rdData;
`endif
    end

    avg_acc_ram #(
        .DEPTH (RECORD_LEN),
        .WIDTH (ACC_W)
    ) uAccRam (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (idxQ),
        .wrData (wrData),
        .rdAddr (idxQ),
        .rdData (rdData)
    );

endmodule

// File: tb/tb_waveform_averager.sv
module tb_waveform_averager;

    localparam int SW = 8;
    localparam int RL = 4;
    localparam int NE = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] sample_in;
    logic          capture_strobe;
    logic          out_ready;
    logic          out_valid;
    logic [AW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          strobe_dropped;

    always #5 clk = ~clk;

    waveform_averager #(
        .SAMPLE_W   (SW),
        .RECORD_LEN (RL),
        .NUM_EVENTS (NE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_in      (sample_in),
        .capture_strobe (capture_strobe),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .strobe_dropped (strobe_dropped)
    );

    int checks = 0;
    int errors = 0;

    int evSamples [NE][RL];
    int expWords [RL];

    typedef struct {
        logic [RL-1:0][15:0] samp;    // element 0 is the rightmost in a concatenation
        logic [RL-1:0][15:0] expRaw;  // raw sums over NE identical events
        int                  readyMode;
        bit                  dropTest;
    } vec_t;

    vec_t tbl [4];

    function automatic int scale(input int s);
`ifdef WAVEFORM_AVG_DIVIDE_EN
        return s / NE;
`else
        return s;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain summation over all events, independent of how the DUT stores it.
    task automatic computeModel();
        for (int i = 0; i < RL; i++) begin
            int s;
            s = 0;
            for (int e = 0; e < NE; e++) s += evSamples[e][i];
            expWords[i] = scale(s);
        end
    endtask

    task automatic runEvent(input int e, input bit dropTest);
        capture_strobe = 1'b1;
        #1;
        check("idle_strobe_not_dropped", strobe_dropped, 0);
        tick();
        capture_strobe = 1'b0;
        for (int i = 0; i < RL; i++) begin
            sample_in = SW'(evSamples[e][i]);
            capture_strobe = dropTest && (i == 1);
            #1;
            check("busy_in_capture", busy, 1);
            if (dropTest && i == 1) check("drop_in_capture", strobe_dropped, 1);
            tick();
            capture_strobe = 1'b0;
        end
        tick();
    endtask

    task automatic runEvents(input int dropEvent);
        for (int e = 0; e < NE; e++) begin
            runEvent(e, e == dropEvent);
            if (e < NE - 1) check("idle_between_events", busy, 0);
        end
    endtask

    // readyMode: 0 always ready, 1 pattern 1,0,0,1 repeating, 2 random
    task automatic runReadout(input int readyMode, input bit dropTest, input int stopAfter);
        int got;
        int cyc;
        int waitV;
        bit stalled;
        logic [AW-1:0] heldData;
        logic heldLast;
        got = 0;
        cyc = 0;
        waitV = 0;
        stalled = 1'b0;
        heldData = '0;
        heldLast = 1'b0;
        while (!out_valid && waitV < 3) begin
            tick();
            waitV++;
        end
        check("first_valid_latency_ok", int'(waitV <= 2), 1);
        while (got < stopAfter && cyc < 100) begin
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            capture_strobe = dropTest && (cyc == 1);
            #1;
            check("valid_in_readout", out_valid, 1);
            if (dropTest && cyc == 1) check("drop_in_readout", strobe_dropped, 1);
            if (stalled) begin
                check("stall_data_stable", out_data, heldData);
                check("stall_last_stable", out_last, heldLast);
            end
            if (out_valid && out_ready) begin
                check($sformatf("word%0d_data", got), out_data, expWords[got]);
                check($sformatf("word%0d_last", got), out_last, int'(got == RL - 1));
                got++;
            end
            stalled = out_valid && !out_ready;
            heldData = out_data;
            heldLast = out_last;
            tick();
            capture_strobe = 1'b0;
            cyc++;
        end
        out_ready = 1'b0;
        if (got < stopAfter) begin
            errors++;
            $display("FAIL readout_timeout: got %0d words expected %0d", got, stopAfter);
        end
        if (stopAfter == RL) check("idle_after_last", busy, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dropped"}, strobe_dropped, 0);
    endtask

    task automatic randomSamples();
        for (int e = 0; e < NE; e++)
            for (int i = 0; i < RL; i++) evSamples[e][i] = int'($urandom_range(0, 255));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].samp = {16'd4, 16'd3, 16'd2, 16'd1};
        tbl[0].expRaw = {16'd16, 16'd12, 16'd8, 16'd4};
        tbl[0].readyMode = 0;
        tbl[0].dropTest = 1'b0;
        tbl[1].samp = {16'd255, 16'd255, 16'd255, 16'd255};
        tbl[1].expRaw = {16'd1020, 16'd1020, 16'd1020, 16'd1020};
        tbl[1].readyMode = 0;
        tbl[1].dropTest = 1'b0;
        tbl[2].samp = {16'd40, 16'd30, 16'd20, 16'd10};
        tbl[2].expRaw = {16'd160, 16'd120, 16'd80, 16'd40};
        tbl[2].readyMode = 1;
        tbl[2].dropTest = 1'b0;
        tbl[3].samp = {16'd1, 16'd100, 16'd0, 16'd7};
        tbl[3].expRaw = {16'd4, 16'd400, 16'd0, 16'd28};
        tbl[3].readyMode = 0;
        tbl[3].dropTest = 1'b1;

        rst = 1'b1;
        sample_in = '0;
        capture_strobe = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        checkResetOutputs("reset");
        rst = 1'b0;
        tick();

        // Table-driven: identical record each event
        for (int t = 0; t < 4; t++) begin
            for (int e = 0; e < NE; e++)
                for (int i = 0; i < RL; i++) evSamples[e][i] = int'(tbl[t].samp[i]);
            for (int i = 0; i < RL; i++) expWords[i] = scale(int'(tbl[t].expRaw[i]));
            runEvents(tbl[t].dropTest ? 2 : -1);
            runReadout(tbl[t].readyMode, tbl[t].dropTest, RL);
            tick();
        end

        // Randomized samples and backpressure against the summation model
        for (int r = 0; r < 4; r++) begin
            randomSamples();
            computeModel();
            runEvents(-1);
            runReadout(2, 1'b0, RL);
            tick();
        end

        // Reset during the capture of event 2, then four fresh events of 5s
        randomSamples();
        runEvent(0, 1'b0);
        runEvent(1, 1'b0);
        capture_strobe = 1'b1;
        tick();
        capture_strobe = 1'b0;
        sample_in = 8'd99;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkResetOutputs("reset_mid_capture");
        rst = 1'b0;
        tick();
        for (int e = 0; e < NE; e++)
            for (int i = 0; i < RL; i++) evSamples[e][i] = 5;
        computeModel();
        runEvents(-1);
        runReadout(0, 1'b0, RL);
        tick();

        // Reset partway through a readout, then a complete fresh average
        randomSamples();
        computeModel();
        runEvents(-1);
        runReadout(0, 1'b0, 2);
        rst = 1'b1;
        tick();
        checkResetOutputs("reset_mid_readout");
        rst = 1'b0;
        tick();
        randomSamples();
        computeModel();
        runEvents(-1);
        runReadout(1, 1'b0, RL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/waveform_averager.md
WAVEFORM_AVERAGER -- requirements
Module: waveform_averager

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8: ADC sample width, unsigned.
REQ-002 SHALL have parameter RECORD_LEN, default 128: samples per event, range 2..4096.
REQ-003 SHALL have parameter NUM_EVENTS, default 64: events summed per average, power of two, range 2..1024.
REQ-004 SHALL have derived parameter ACC_W = SAMPLE_W + log2(NUM_EVENTS): accumulator and output width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port sample_in, input, SAMPLE_W bits: ADC sample, valid every cycle.
REQ-008 SHALL have port capture_strobe, input, 1 bit: trigger that starts one event record.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts a word.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_data, output, ACC_W bits: averaged or summed sample.
REQ-012 SHALL have port out_last, output, 1 bit: marks word RECORD_LEN-1 of a readout.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port strobe_dropped, output, 1 bit: one-cycle pulse when capture_strobe is ignored.

Function
REQ-015 SHALL implement states IDLE, CAPTURE, EVENT_DONE and READOUT.
REQ-016 SHALL move IDLE->CAPTURE on the cycle after capture_strobe=1; sample index 0 is sample_in in the first CAPTURE cycle.
REQ-017 SHALL capture exactly one sample per CAPTURE cycle for RECORD_LEN consecutive cycles, then enter EVENT_DONE.
REQ-018 SHALL write acc[i] = sample for event 0 and acc[i] = acc[i] + sample for events 1..NUM_EVENTS-1, zero-extended to ACC_W, with no overflow possible.
REQ-019 SHALL increment the event counter in EVENT_DONE, go to READOUT if the counter reaches NUM_EVENTS, else go to IDLE.
REQ-020 SHALL in READOUT present acc[0..RECORD_LEN-1] in order with valid/ready; a word transfers when out_valid and out_ready are both 1.
REQ-021 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL sustain one word per cycle when out_ready is held high; first out_valid no later than 2 cycles after READOUT entry.
REQ-023 SHALL after the out_last transfer clear the event counter and return to IDLE.
REQ-024 SHALL ignore capture_strobe in CAPTURE, EVENT_DONE and READOUT, and pulse strobe_dropped in that cycle.
REQ-025 SHALL make the sample and word index counters wrap to 0 at RECORD_LEN, never beyond.

Reset
REQ-026 SHALL on rst=1 enter IDLE, zero all counters, and drive out_valid=0, out_last=0, busy=0 and strobe_dropped=0 at the next edge, including mid-CAPTURE and mid-READOUT.
REQ-027 SHALL not clear accumulator memory on reset; the event-0 overwrite makes stale contents harmless.
REQ-028 SHALL make out_data a don't-care while out_valid=0.

Configuration
REQ-029 SHALL, when macro WAVEFORM_AVG_DIVIDE_EN is defined, output acc[i] >> log2(NUM_EVENTS), truncated and zero-extended to ACC_W.
REQ-030 SHALL, when WAVEFORM_AVG_DIVIDE_EN is undefined, output the raw ACC_W-bit sum.

Structure
REQ-031 SHALL place the state encoding type and a clog2 helper constant function in package waveform_averager_pkg.
REQ-032 SHALL implement accumulator storage as sub-module avg_acc_ram: RECORD_LEN x ACC_W, one read port and one write port, read-before-write, sustaining one read-modify-write per cycle.

Verification
REQ-033 SHALL cover averaging: RECORD_LEN=4, NUM_EVENTS=4, samples {1,2,3,4} each event, divide off -> outputs {4,8,12,16}, out_last on the 4th word.
REQ-034 SHALL cover divide on: same stimulus with WAVEFORM_AVG_DIVIDE_EN -> outputs {1,2,3,4}.
REQ-035 SHALL cover max values: SAMPLE_W=8, samples 255 for 4 events -> each word 1020, no wrap.
REQ-036 SHALL cover backpressure: out_ready toggling 1,0,0,1 -> no lost or duplicated words, data stable while stalled.
REQ-037 SHALL cover dropped strobes: strobe during CAPTURE and READOUT -> strobe_dropped pulses, record unaffected.
REQ-038 SHALL cover reset mid-event: rst during event 2 CAPTURE, then 4 fresh events of {5,5,5,5} -> outputs {20,20,20,20}.
